// File: rtl/edge_pkg.sv
// Shared types and frame-geometry helpers for the edge-detection datapath.
package edge_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_t;

    localparam int DEF_WIDTH   = 352;
    localparam int DEF_HEIGHT  = 288;
    localparam int ROW_WIDTH   = DEF_WIDTH / 4;
    localparam int FRAME_WORDS = DEF_WIDTH * DEF_HEIGHT / 4;

    // Words per row when four pixels are packed into each word.
    function automatic int row_width(input int width);
        return width / 4;
    endfunction

    // Words per frame for the given geometry.
    function automatic int frame_words(input int width, input int height);
        return width * height / 4;
    endfunction

endpackage

// File: rtl/line_buffer_2bank.sv
// Two row banks with one write port and a synchronous dual read at a shared column.
// rd_cur returns bank[rd_bank][rd_col]; rd_other returns the opposite bank at the same column.
module line_buffer_2bank
    import edge_pkg::*;
#(
    parameter int DEPTH = ROW_WIDTH,
    parameter int COL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [COL_W-1:0] wr_col,
    input  word_t            wr_data,
    input  logic             rd_en,
    input  logic             rd_bank,
    input  logic [COL_W-1:0] rd_col,
    output word_t            rd_cur,
    output word_t            rd_other
);

    word_t bank0 [DEPTH];
    word_t bank1 [DEPTH];

    // Storage write; the contents need no reset since every word is filled before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank) begin
                bank1[wr_col] <= wr_data;
            end else begin
                bank0[wr_col] <= wr_data;
            end
        end
    end

    // Registered dual read; the output registers hold their value between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cur   <= '0;
            rd_other <= '0;
        end else if (rd_en) begin
            rd_cur   <= rd_bank ? bank1[rd_col] : bank0[rd_col];
            rd_other <= rd_bank ? bank0[rd_col] : bank1[rd_col];
        end
    end

endmodule

// File: rtl/row_cache.sv
// Line-buffer front end for the edge accelerator: fills row 0, then serves three-row
// column reads while prefetching the next row, and forwards result words to the output
// frame. Owns the single memory port.
module row_cache
    import edge_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = FRAME_WORDS,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    input  word_t             mem_dataR,
    output word_t             mem_dataW,
    input  logic              acc_en,
    input  logic              acc_we,
    input  word_t             acc_dataW,
    output word_t             dataRa,
    output word_t             dataRb,
    output word_t             dataRc,
    output logic              row_cached,
    output logic              done
);

    localparam int RW     = row_width(WIDTH);
    localparam int FW     = frame_words(WIDTH, HEIGHT);
    localparam int COL_W  = (RW > 1) ? $clog2(RW) : 1;
    localparam int FCNT_W = $clog2(RW + 1);
    localparam int ROW_W  = $clog2(HEIGHT + 1);
    localparam int WCNT_W = $clog2(FW + 1);

    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(RW - 1);
    localparam logic [FCNT_W-1:0] FCNT_END    = FCNT_W'(RW);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(HEIGHT - 1);
    localparam logic [ROW_W-1:0]  ROW_END     = ROW_W'(HEIGHT);
    localparam logic [WCNT_W-1:0] WCNT_LAST   = WCNT_W'(FW - 1);
    localparam logic [WCNT_W-1:0] WCNT_END    = WCNT_W'(FW);
    localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(RW);
    localparam logic [ADDR_W-1:0] IN_ADDR     = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] OUT_ADDR    = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] FIRST_FETCH = ADDR_W'(IN_BASE + RW);

    state_t state_q, state_d;

    logic [FCNT_W-1:0] fcnt_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              sel_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [WCNT_W-1:0] wcnt_q;

    logic              fill_pend_q;
    logic              strm_pend_q;
    logic [COL_W-1:0]  pend_col_q;
    logic              pend_bank_q;
    logic              strm_first_q;
    logic              strm_last_q;
    word_t             hold_c_q;

    logic  fill_issue;
    logic  rd_req;
    logic  wr_req;
    logic  row_is_last;
    logic  stream_fetch;
    logic  lb_wr_en;
    word_t lb_cur;
    word_t lb_other;
    word_t data_rc_live;

    assign fill_issue   = (state_q == FILL) && (fcnt_q < FCNT_END);
    assign rd_req       = (state_q == STREAM) && acc_en && !acc_we && (row_q != ROW_END);
    assign wr_req       = (state_q == STREAM) && acc_en && acc_we && (wcnt_q != WCNT_END);
    assign row_is_last  = (row_q == ROW_LAST);
    assign stream_fetch = rd_req && !row_is_last;

    // Row r+1 replaces row r-1 in the opposite bank; the last row fetches nothing.
    assign lb_wr_en = fill_pend_q || (strm_pend_q && !strm_last_q);

    line_buffer_2bank #(
        .DEPTH (RW),
        .COL_W (COL_W)
    ) u_line_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (lb_wr_en),
        .wr_bank  (pend_bank_q),
        .wr_col   (pend_col_q),
        .wr_data  (mem_dataR),
        .rd_en    (rd_req),
        .rd_bank  (sel_q),
        .rd_col   (col_q),
        .rd_cur   (lb_cur),
        .rd_other (lb_other)
    );

    // State register; an asynchronous reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = FILL;
            FILL:   if (fill_pend_q && (pend_col_q == COL_LAST)) state_d = STREAM;
            STREAM: if (wr_req && (wcnt_q == WCNT_LAST)) state_d = DONE;
            DONE:   if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fill, column, row, bank-select and write counters; all cleared while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            sel_q      <= 1'b0;
            row_base_q <= FIRST_FETCH;
            wcnt_q     <= '0;
        end else if (state_q == IDLE) begin
            fcnt_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            sel_q      <= 1'b0;
            row_base_q <= FIRST_FETCH;
            wcnt_q     <= '0;
        end else begin
            if (fill_issue) begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
            if (rd_req) begin
                if (col_q == COL_LAST) begin
                    col_q      <= '0;
                    row_q      <= row_q + ROW_W'(1);
                    sel_q      <= ~sel_q;
                    row_base_q <= row_base_q + ROW_STEP;
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            if (wr_req) begin
                wcnt_q <= wcnt_q + WCNT_W'(1);
            end
        end
    end

    // Track where the word returning next cycle belongs, and hold the row r+1 word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_pend_q  <= 1'b0;
            strm_pend_q  <= 1'b0;
            pend_col_q   <= '0;
            pend_bank_q  <= 1'b0;
            strm_first_q <= 1'b0;
            strm_last_q  <= 1'b0;
            hold_c_q     <= '0;
        end else begin
            fill_pend_q <= fill_issue;
            strm_pend_q <= rd_req;
            if (fill_issue) begin
                pend_col_q  <= COL_W'(fcnt_q);
                pend_bank_q <= sel_q;
            end else if (rd_req) begin
                pend_col_q   <= col_q;
                pend_bank_q  <= ~sel_q;
                strm_first_q <= (row_q == '0);
                strm_last_q  <= row_is_last;
            end
            if (strm_pend_q) begin
                hold_c_q <= data_rc_live;
            end
        end
    end

    // Row r+1 comes straight from memory on the response cycle and from the hold register after.
    always_comb begin
        data_rc_live = strm_last_q ? '0 : mem_dataR;
        dataRb       = lb_cur;
        dataRa       = strm_first_q ? lb_cur : lb_other;
        dataRc       = strm_pend_q ? data_rc_live : hold_c_q;
    end

    // Memory port mux: fill reads, next-row prefetch reads, or result writes.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_dataW = '0;
        if (fill_issue) begin
            mem_en   = 1'b1;
            mem_addr = IN_ADDR + ADDR_W'(fcnt_q);
        end else if (stream_fetch) begin
            mem_en   = 1'b1;
            mem_addr = row_base_q + ADDR_W'(col_q);
        end else if (wr_req) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = OUT_ADDR + ADDR_W'(wcnt_q);
            mem_dataW = acc_dataW;
        end
    end

    // Status flags decoded from the state.
    always_comb begin
        done       = (state_q == DONE);
        row_cached = (state_q == STREAM) || (state_q == DONE);
    end

endmodule

// File: tb/tb_row_cache.sv
// Directed bench for row_cache on a 16x4 frame with a synchronous word memory model.
module tb_row_cache;

    localparam int WIDTH    = 16;
    localparam int HEIGHT   = 4;
    localparam int RW       = WIDTH / 4;
    localparam int OUT_BASE = 16;
    localparam int ADDR_W   = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;
    logic [31:0]       mem_dataR;
    logic [31:0]       mem_dataW;
    logic              acc_en;
    logic              acc_we;
    logic [31:0]       acc_dataW;
    logic [31:0]       dataRa;
    logic [31:0]       dataRb;
    logic [31:0]       dataRc;
    logic              row_cached;
    logic              done;

    logic              load_mem;
    logic [31:0]       mem [64];

    int n_asserts = 0;
    int n_fails   = 0;

    row_cache #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .IN_BASE  (0),
        .OUT_BASE (OUT_BASE),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_dataR  (mem_dataR),
        .mem_dataW  (mem_dataW),
        .acc_en     (acc_en),
        .acc_we     (acc_we),
        .acc_dataW  (acc_dataW),
        .dataRa     (dataRa),
        .dataRb     (dataRb),
        .dataRc     (dataRc),
        .row_cached (row_cached),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: input frame words 0..15 hold 0x100+i, everything else starts at 0.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i < 16) ? (32'h100 + 32'(i)) : 32'h0;
            end
            mem_dataR <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[5:0]] <= mem_dataW;
            end else begin
                mem_dataR <= mem[mem_addr[5:0]];
            end
        end
    end

    function automatic logic [31:0] pix(input int idx);
        return 32'h100 + 32'(idx);
    endfunction

    task automatic applyStimulus(input logic s, input logic en, input logic we,
                                 input logic [31:0] wdata);
        start     = s;
        acc_en    = en;
        acc_we    = we;
        acc_dataW = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One stream read at row r, column c: check the issued fetch, then the three row words.
    task automatic doRead(input int r, input int c);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        if (r < HEIGHT - 1) begin
            checkOutput($sformatf("rd_en r%0d c%0d", r, c), 32'(mem_en), 32'd1);
            checkOutput($sformatf("rd_we r%0d c%0d", r, c), 32'(mem_we), 32'd0);
            checkOutput($sformatf("rd_addr r%0d c%0d", r, c), 32'(mem_addr),
                        32'((r + 1) * RW + c));
        end else begin
            checkOutput($sformatf("rd_en_last r%0d c%0d", r, c), 32'(mem_en), 32'd0);
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput($sformatf("dataRb r%0d c%0d", r, c), dataRb, pix(r * RW + c));
        checkOutput($sformatf("dataRa r%0d c%0d", r, c), dataRa,
                    (r == 0) ? pix(c) : pix((r - 1) * RW + c));
        checkOutput($sformatf("dataRc r%0d c%0d", r, c), dataRc,
                    (r < HEIGHT - 1) ? pix((r + 1) * RW + c) : 32'h0);
    endtask

    initial begin
        load_mem = 1'b1;
        rst      = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);

        // Reset state.
        @(negedge clk);
        #1;
        checkOutput("rst mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst row_cached", 32'(row_cached), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst dataRa", dataRa, 32'h0);
        checkOutput("rst dataRb", dataRb, 32'h0);
        checkOutput("rst dataRc", dataRc, 32'h0);
        load_mem = 1'b0;
        rst      = 1'b1;

        // Row 0 fill with acc write requests held high that must be ignored.
        $display("[TB] fill row 0");
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        for (int k = 0; k < RW; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("fill_en %0d", k), 32'(mem_en), 32'd1);
            checkOutput($sformatf("fill_we %0d", k), 32'(mem_we), 32'd0);
            checkOutput($sformatf("fill_addr %0d", k), 32'(mem_addr), 32'(k));
            checkOutput($sformatf("fill_cached %0d", k), 32'(row_cached), 32'd0);
        end
        @(negedge clk);
        #1;
        checkOutput("fill drain mem_en", 32'(mem_en), 32'd0);
        checkOutput("fill drain row_cached", 32'(row_cached), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("cycle6 row_cached", 32'(row_cached), 32'd1);
        checkOutput("cycle6 mem_en", 32'(mem_en), 32'd0);

        // Row 0, column 0 read, then the outputs must hold through an idle cycle.
        $display("[TB] stream reads");
        doRead(0, 0);
        @(negedge clk);
        #1;
        checkOutput("hold dataRa", dataRa, pix(0));
        checkOutput("hold dataRb", dataRb, pix(0));
        checkOutput("hold dataRc", dataRc, pix(4));

        // Remaining columns and rows, crossing every row wrap and the last row.
        for (int c = 1; c < RW; c++) doRead(0, c);
        for (int r = 1; r < HEIGHT; r++) begin
            for (int c = 0; c < RW; c++) doRead(r, c);
        end

        // A read after the last row is ignored and the outputs keep their values.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("extra rd mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("extra rd dataRb", dataRb, pix(15));
        checkOutput("extra rd dataRa", dataRa, pix(11));
        checkOutput("extra rd dataRc", dataRc, 32'h0);

        // Result writes into the output frame.
        $display("[TB] result writes");
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b1, 1'b1, 32'hA0 + 32'(k));
            #1;
            checkOutput($sformatf("wr_en %0d", k), 32'(mem_en), 32'd1);
            checkOutput($sformatf("wr_we %0d", k), 32'(mem_we), 32'd1);
            checkOutput($sformatf("wr_addr %0d", k), 32'(mem_addr), 32'(OUT_BASE + k));
            checkOutput($sformatf("wr_data %0d", k), mem_dataW, 32'hA0 + 32'(k));
            checkOutput($sformatf("wr_done %0d", k), 32'(done), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b1, 1'b1, 32'hF0 + 32'(k));
            #1;
            checkOutput($sformatf("drop mem_en %0d", k), 32'(mem_en), 32'd0);
            checkOutput($sformatf("drop done %0d", k), 32'(done), 32'd1);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("done before idle", 32'(done), 32'd1);
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("out mem %0d", k), mem[OUT_BASE + k], 32'hA0 + 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("no overrun %0d", k), mem[32 + k], 32'h0);
        end
        @(negedge clk);
        #1;
        checkOutput("idle done", 32'(done), 32'd0);
        checkOutput("idle row_cached", 32'(row_cached), 32'd0);

        // Second frame, aborted by reset in the middle of streaming.
        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        begin
            int cycles;
            cycles = 0;
            while (!row_cached && cycles < 20) begin
                @(negedge clk);
                #1;
                cycles++;
            end
        end
        checkOutput("refill row_cached", 32'(row_cached), 32'd1);
        doRead(0, 0);
        doRead(0, 1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort mem_en", 32'(mem_en), 32'd0);
        checkOutput("abort mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("abort dataRa", dataRa, 32'h0);
        checkOutput("abort dataRb", dataRb, 32'h0);
        checkOutput("abort dataRc", dataRc, 32'h0);
        checkOutput("abort row_cached", 32'(row_cached), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post reset idle mem_en", 32'(mem_en), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < RW; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("refill_en %0d", k), 32'(mem_en), 32'd1);
            checkOutput($sformatf("refill_addr %0d", k), 32'(mem_addr), 32'(k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
